// File: rtl/async_event_sender_if.sv
// Event-sender bundle: event input, async ack, request level and status.
// master = sender side, slave = event source plus far-domain responder.
interface async_event_sender_if #(
   parameter int CNT_W = 4
);
   logic             ev_in;
   logic             ack_async;
   logic             req_out;
   logic             busy;
   logic [CNT_W-1:0] pend_cnt;
   logic             overflow;
   logic             tmo_err;

   modport master (
      input  ev_in,
      input  ack_async,
      output req_out,
      output busy,
      output pend_cnt,
      output overflow,
      output tmo_err
   );

   modport slave (
      output ev_in,
      output ack_async,
      input  req_out,
      input  busy,
      input  pend_cnt,
      input  overflow,
      input  tmo_err
   );
endinterface

// File: rtl/async_event_sender.sv
// Source-domain end of a 4-phase req/ack event crossing with a saturating queue.
// Optional REQ timeout enabled by defining ASYNC_EVENT_SENDER_TIMEOUT_EN.
module async_event_sender #(
   parameter int CNT_W       = 4,
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                 clk,
   input  logic                 rst,
   async_event_sender_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      REL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("async_event_sender: SYNC_STAGES must be >= 2");
   end
   if (TIMEOUT_CYC < 2) begin : g_bad_tmo
      $error("async_event_sender: TIMEOUT_CYC must be >= 2");
   end

   state_t           state;
   logic             req_q;
   logic             busy_q;
   logic             ovf_q;
   logic [CNT_W-1:0] cnt;
   logic             ack_s;
   logic             full;
   logic             inc;
   logic             start;

   (* async_reg = "true" *)
   logic [SYNC_STAGES-1:0] ack_sync;

   assign ack_s = ack_sync[SYNC_STAGES-1];
   assign full  = (cnt == CNT_MAX);
   assign inc   = bus.ev_in & ~full;
   assign start = (state == IDLE) & (cnt != '0);

   // Resynchronise the far-domain ack before the FSM looks at it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_sync <= '0;
      end else begin
         ack_sync <= {ack_sync[SYNC_STAGES-2:0], bus.ack_async};
      end
   end

   // Pending-event counter: saturates at max, never wraps.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt   <= '0;
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= bus.ev_in & full;
         unique case ({inc, start})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef ASYNC_EVENT_SENDER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic [TW-1:0] tcnt;
   logic          tmo_q;
   logic          tmo_hit;

   assign tmo_hit = (tcnt == TMO_LAST);
   assign bus.tmo_err = tmo_q;

   // Handshake FSM with REQ timeout; req/busy are state-decoded registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         busy_q <= 1'b0;
         tcnt   <= '0;
         tmo_q  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= REQ;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
                  tcnt   <= '0;
               end
            end
            REQ: begin
               if (ack_s) begin
                  state <= REL;
                  req_q <= 1'b0;
               end else if (tmo_hit) begin
                  state <= REL;
                  req_q <= 1'b0;
                  tmo_q <= 1'b1;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end
            REL: begin
               if (!ack_s) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               req_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end
`else
   assign bus.tmo_err = 1'b0;

   // Handshake FSM; req/busy are state-decoded registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         req_q  <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state  <= REQ;
                  req_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            REQ: begin
               if (ack_s) begin
                  state <= REL;
                  req_q <= 1'b0;
               end
            end
            REL: begin
               if (!ack_s) begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            end
            default: begin
               state  <= IDLE;
               req_q  <= 1'b0;
               busy_q <= 1'b0;
            end
         endcase
      end
   end
`endif

   assign bus.req_out  = req_q;
   assign bus.busy     = busy_q;
   assign bus.pend_cnt = cnt;
   assign bus.overflow = ovf_q;

endmodule
